// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - instruction-memory request/response bundle between fetch and imem
interface fetch_unit_if #(
    parameter int ADDR_W  = 16,
    parameter int INSTR_W = 16
);
    logic               imem_req;
    logic [ADDR_W-1:0]  imem_addr;
    logic               imem_ready;
    logic [INSTR_W-1:0] imem_rdata;
    logic               imem_err;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rdata,
        input  imem_err
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rdata,
        output imem_err
    );
endinterface

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - PC, imem handshake and IF/ID register for the 16-bit core
module fetch_unit #(
    parameter int                ADDR_W     = 16,
    parameter int                INSTR_W    = 16,
    parameter logic [ADDR_W-1:0] RESET_PC   = 16'h0000,
    parameter logic [ADDR_W-1:0] EXC_VECTOR = 16'h0002
) (
    input  logic               clk,
    input  logic               reset_n,
    fetch_unit_if.master       imem,
    input  logic               stall,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirect_pc,
    input  logic               halt,
    input  logic               exc_in,
    input  logic [ADDR_W-1:0]  exc_pc,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  instr_pc,
    output logic               instr_valid,
    output logic               inst_memory_exception,
    output logic [ADDR_W-1:0]  epc,
    output logic               halted
);

    typedef enum logic [2:0] {
        S_FETCH,
        S_WAIT,
        S_HOLD,
        S_DRAIN,
        S_HALTED
    } state_t;

    state_t             state;
    logic [ADDR_W-1:0]  pc;
    logic [ADDR_W-1:0]  req_addr;
    logic [INSTR_W-1:0] hold_instr;
    logic [ADDR_W-1:0]  hold_pc;

    logic live;
    logic resp;
    logic imem_exc;
    logic ev_exc;
    logic ev_imem;
    logic ev_halt;
    logic ev_redir;
    logic flush;
    logic still_out;

    // Decode this cycle's control events in priority order; a halted core ignores them all.
    always_comb begin
        live      = !halted;
        resp      = (state == S_WAIT) && imem.imem_ready;
        imem_exc  = (resp && imem.imem_err) || ((state == S_FETCH) && pc[0]);
        ev_exc    = live && exc_in;
        ev_imem   = live && !exc_in && imem_exc;
        ev_halt   = live && !exc_in && !imem_exc && halt;
        ev_redir  = live && !exc_in && !imem_exc && !halt && redirect;
        flush     = ev_exc || ev_imem || ev_halt || ev_redir;
        // A flush that leaves a request still in flight must drain its response first.
        still_out = ((state == S_WAIT) || (state == S_DRAIN)) && !imem.imem_ready;
    end

    // Request is issued straight from FETCH; the address is held in req_addr while outstanding.
    always_comb begin
        imem.imem_req  = 1'b0;
        imem.imem_addr = req_addr;
        case (state)
            S_FETCH: begin
                imem.imem_req  = reset_n && !stall && !pc[0] && !exc_in && !halt && !redirect;
                imem.imem_addr = pc;
            end
            S_WAIT, S_DRAIN: imem.imem_req = 1'b1;
            default: imem.imem_req = 1'b0;
        endcase
    end

    // Fetch FSM with PC, IF/ID, hold buffer and exception state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state                 <= S_FETCH;
            pc                    <= RESET_PC;
            req_addr              <= '0;
            hold_instr            <= '0;
            hold_pc               <= '0;
            instr                 <= '0;
            instr_pc              <= '0;
            instr_valid           <= 1'b0;
            inst_memory_exception <= 1'b0;
            epc                   <= '0;
            halted                <= 1'b0;
        end else begin
            inst_memory_exception <= 1'b0;
            if (flush) begin
                instr_valid <= 1'b0;
                if (ev_exc) begin
                    epc <= exc_pc;
                    pc  <= EXC_VECTOR;
                end else if (ev_imem) begin
                    epc                   <= (state == S_FETCH) ? pc : req_addr;
                    pc                    <= EXC_VECTOR;
                    inst_memory_exception <= 1'b1;
                end else if (ev_halt) begin
                    halted <= 1'b1;
                end else begin
                    pc <= redirect_pc;
                end
                if (still_out)
                    state <= S_DRAIN;
                else if (ev_halt)
                    state <= S_HALTED;
                else
                    state <= S_FETCH;
            end else begin
                case (state)
                    S_FETCH: begin
                        if (!stall) begin
                            instr_valid <= 1'b0;
                            req_addr    <= pc;
                            state       <= S_WAIT;
                        end
                    end
                    S_WAIT: begin
                        if (imem.imem_ready) begin
                            pc <= pc + ADDR_W'(2);
                            if (!stall) begin
                                instr       <= imem.imem_rdata;
                                instr_pc    <= pc;
                                instr_valid <= 1'b1;
                                state       <= S_FETCH;
                            end else begin
                                hold_instr <= imem.imem_rdata;
                                hold_pc    <= pc;
                                state      <= S_HOLD;
                            end
                        end else if (!stall) begin
                            instr_valid <= 1'b0;
                        end
                    end
                    S_HOLD: begin
                        if (!stall) begin
                            instr       <= hold_instr;
                            instr_pc    <= hold_pc;
                            instr_valid <= 1'b1;
                            state       <= S_FETCH;
                        end
                    end
                    S_DRAIN: begin
                        if (!stall)
                            instr_valid <= 1'b0;
                        if (imem.imem_ready)
                            state <= halted ? S_HALTED : S_FETCH;
                    end
                    default: begin
                        instr_valid <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed table-driven bench for fetch_unit
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        stall;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        halt;
    logic        exc_in;
    logic [15:0] exc_pc;
    logic [15:0] instr;
    logic [15:0] instr_pc;
    logic        instr_valid;
    logic        inst_memory_exception;
    logic [15:0] epc;
    logic        halted;

    int total  = 0;
    int passed = 0;

    fetch_unit_if #(.ADDR_W(16), .INSTR_W(16)) bus ();

    fetch_unit dut (
        .clk                   (clk),
        .reset_n               (reset_n),
        .imem                  (bus),
        .stall                 (stall),
        .redirect              (redirect),
        .redirect_pc           (redirect_pc),
        .halt                  (halt),
        .exc_in                (exc_in),
        .exc_pc                (exc_pc),
        .instr                 (instr),
        .instr_pc              (instr_pc),
        .instr_valid           (instr_valid),
        .inst_memory_exception (inst_memory_exception),
        .epc                   (epc),
        .halted                (halted)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] pc;
        logic [15:0] word;
        int          lat;
    } vec_t;

    vec_t vecs [6];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %b expected %b", name, act, exp);
    endtask

    task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Act as instruction memory for one fetch, then check the IF/ID register.
    task automatic serve(input logic [15:0] addr, input logic [15:0] word, input int lat, input string name);
        int n = 0;
        while (bus.imem_req !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk1({name, " req"}, bus.imem_req, 1'b1);
        chk16({name, " addr"}, bus.imem_addr, addr);
        repeat (lat) tick();
        bus.imem_ready = 1'b1;
        bus.imem_rdata = word;
        tick();
        bus.imem_ready = 1'b0;
        bus.imem_rdata = 16'h0000;
        chk1({name, " valid"}, instr_valid, 1'b1);
        chk16({name, " instr"}, instr, word);
        chk16({name, " instr_pc"}, instr_pc, addr);
    endtask

    initial begin
        vecs[0] = '{16'h0000, 16'h05AF, 1};
        vecs[1] = '{16'h0002, 16'h8A5F, 1};
        vecs[2] = '{16'h0004, 16'h1111, 2};
        vecs[3] = '{16'h0006, 16'hF00D, 3};
        vecs[4] = '{16'h0008, 16'h0000, 1};
        vecs[5] = '{16'h000A, 16'hFFFF, 4};

        reset_n        = 1'b0;
        stall          = 1'b0;
        redirect       = 1'b0;
        redirect_pc    = 16'h0000;
        halt           = 1'b0;
        exc_in         = 1'b0;
        exc_pc         = 16'h0000;
        bus.imem_ready = 1'b0;
        bus.imem_rdata = 16'h0000;
        bus.imem_err   = 1'b0;

        tick();
        tick();
        chk1("reset req", bus.imem_req, 1'b0);
        chk1("reset valid", instr_valid, 1'b0);
        chk16("reset instr", instr, 16'h0000);
        chk16("reset instr_pc", instr_pc, 16'h0000);
        chk16("reset epc", epc, 16'h0000);
        chk1("reset halted", halted, 1'b0);
        chk1("reset exc", inst_memory_exception, 1'b0);
        reset_n = 1'b1;
        #1;

        // Straight-line fetch with varying memory latency.
        for (int i = 0; i < 6; i++)
            serve(vecs[i].pc, vecs[i].word, vecs[i].lat, $sformatf("vec%0d", i));

        // Stall with no outstanding request keeps the live word.
        stall = 1'b1;
        #1;
        chk1("stall no req", bus.imem_req, 1'b0);
        tick();
        chk1("stall keeps valid", instr_valid, 1'b1);
        chk16("stall keeps instr", instr, 16'hFFFF);

        // Stall while a request is outstanding: word parks in the hold buffer.
        stall = 1'b0;
        #1;
        chk16("hold issue addr", bus.imem_addr, 16'h000C);
        tick();
        stall          = 1'b1;
        bus.imem_ready = 1'b1;
        bus.imem_rdata = 16'h1234;
        tick();
        bus.imem_ready = 1'b0;
        chk1("hold req low", bus.imem_req, 1'b0);
        chk16("hold old instr", instr, 16'hFFFF);
        chk1("hold valid low", instr_valid, 1'b0);
        tick();
        tick();
        chk1("hold still no req", bus.imem_req, 1'b0);
        stall = 1'b0;
        tick();
        chk1("hold release valid", instr_valid, 1'b1);
        chk16("hold release instr", instr, 16'h1234);
        chk16("hold release pc", instr_pc, 16'h000C);
        serve(16'h000E, 16'h2345, 1, "after hold");

        // Redirect while WAIT: stale response dropped.
        tick();
        redirect    = 1'b1;
        redirect_pc = 16'h0040;
        tick();
        redirect = 1'b0;
        chk1("drain req", bus.imem_req, 1'b1);
        chk16("drain old addr", bus.imem_addr, 16'h0010);
        chk1("drain valid low", instr_valid, 1'b0);
        bus.imem_ready = 1'b1;
        bus.imem_rdata = 16'hDEAD;
        tick();
        bus.imem_ready = 1'b0;
        chk1("stale dropped", instr_valid, 1'b0);
        chk1("no exc after drain", inst_memory_exception, 1'b0);
        serve(16'h0040, 16'h3456, 2, "redirect target");

        // Bus error on fetch at 0x0010.
        redirect    = 1'b1;
        redirect_pc = 16'h0010;
        #1;
        chk1("redirect gates req", bus.imem_req, 1'b0);
        tick();
        redirect = 1'b0;
        #1;
        chk16("err fetch addr", bus.imem_addr, 16'h0010);
        tick();
        bus.imem_ready = 1'b1;
        bus.imem_err   = 1'b1;
        tick();
        bus.imem_ready = 1'b0;
        bus.imem_err   = 1'b0;
        stall          = 1'b1;
        #1;
        chk1("err exc pulse", inst_memory_exception, 1'b1);
        chk16("err epc", epc, 16'h0010);
        chk16("err vector addr", bus.imem_addr, 16'h0002);
        chk1("err valid low", instr_valid, 1'b0);
        tick();
        chk1("err pulse one cycle", inst_memory_exception, 1'b0);

        // Downstream exception wins over a concurrent redirect.
        stall = 1'b0;
        serve(16'h0002, 16'h4567, 1, "vector fetch");
        exc_in      = 1'b1;
        exc_pc      = 16'h0022;
        redirect    = 1'b1;
        redirect_pc = 16'h0080;
        #1;
        chk1("exc gates req", bus.imem_req, 1'b0);
        tick();
        exc_in   = 1'b0;
        redirect = 1'b0;
        #1;
        chk16("exc_in epc", epc, 16'h0022);
        chk16("exc_in vector", bus.imem_addr, 16'h0002);
        chk1("exc_in no pulse", inst_memory_exception, 1'b0);

        // Redirect to an odd address raises a misaligned exception without a request.
        redirect    = 1'b1;
        redirect_pc = 16'h0031;
        tick();
        redirect = 1'b0;
        #1;
        chk1("misaligned no req", bus.imem_req, 1'b0);
        chk16("misaligned pc", bus.imem_addr, 16'h0031);
        tick();
        chk1("misaligned pulse", inst_memory_exception, 1'b1);
        chk16("misaligned epc", epc, 16'h0031);
        chk16("misaligned vector", bus.imem_addr, 16'h0002);

        // Halt while a request is outstanding, then nothing restarts it.
        tick();
        halt = 1'b1;
        tick();
        halt = 1'b0;
        chk1("halted set", halted, 1'b1);
        chk1("halt drain req", bus.imem_req, 1'b1);
        chk1("halt valid low", instr_valid, 1'b0);
        bus.imem_ready = 1'b1;
        bus.imem_rdata = 16'hBEEF;
        tick();
        bus.imem_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            redirect    = 1'b1;
            redirect_pc = 16'h0040;
            exc_in      = 1'b1;
            exc_pc      = 16'h0066;
            #1;
            chk1($sformatf("halted req %0d", i), bus.imem_req, 1'b0);
            tick();
        end
        redirect = 1'b0;
        exc_in   = 1'b0;
        chk1("still halted", halted, 1'b1);
        chk16("halted epc kept", epc, 16'h0031);
        chk1("halted valid", instr_valid, 1'b0);

        // Reset pulse restarts fetch at RESET_PC; a late ready is ignored.
        reset_n = 1'b0;
        #1;
        chk1("rst halted clr", halted, 1'b0);
        chk1("rst req", bus.imem_req, 1'b0);
        chk16("rst epc", epc, 16'h0000);
        bus.imem_ready = 1'b1;
        bus.imem_rdata = 16'hDEAD;
        tick();
        reset_n = 1'b1;
        #1;
        chk1("restart req", bus.imem_req, 1'b1);
        chk16("restart addr", bus.imem_addr, 16'h0000);
        tick();
        bus.imem_ready = 1'b0;
        chk1("late ready ignored", instr_valid, 1'b0);
        serve(16'h0000, 16'h05AF, 1, "restart");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
